// File: rtl/imm_extend_pipe.sv
// Two-stage pipelined immediate extractor/extender for the decode stage.
// Optional macro IMM_BRANCH_SHIFT_EN: CB/B immediates are scaled by 4 (<< 2).
module imm_extend_pipe #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [1:0]       fmt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] imm,
    output logic [1:0]       out_fmt
);

    localparam logic [1:0] FMT_D  = 2'd0;
    localparam logic [1:0] FMT_CB = 2'd1;
    localparam logic [1:0] FMT_B  = 2'd2;

    // No format looks above bit 25, so S1 stores only the low bits.
    logic             s1_valid_q, s1_valid_d;
    logic [25:0]      s1_instr_q, s1_instr_d;
    logic [1:0]       s1_fmt_q, s1_fmt_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] imm_q, imm_d;
    logic [1:0]       out_fmt_q, out_fmt_d;
    logic [OUT_W-1:0] ext;
    logic             s2_adv, accept;
    logic             unused_hi;

    assign unused_hi = ^instr[31:26];

    assign s2_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        ext = '0;
        case (s1_fmt_q)
            FMT_D:   ext = {{(OUT_W-9){s1_instr_q[20]}},  s1_instr_q[20:12]};
            FMT_CB:  ext = {{(OUT_W-19){s1_instr_q[23]}}, s1_instr_q[23:5]};
            FMT_B:   ext = {{(OUT_W-26){s1_instr_q[25]}}, s1_instr_q[25:0]};
            default: ext = {{(OUT_W-12){1'b0}},           s1_instr_q[21:10]};
        endcase
`ifdef IMM_BRANCH_SHIFT_EN
        if (s1_fmt_q == FMT_CB || s1_fmt_q == FMT_B)
            ext = ext << 2;
`endif
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_instr_d = s1_instr_q;
        s1_fmt_d   = s1_fmt_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_instr_d = instr[25:0];
            s1_fmt_d   = fmt;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Output stage: refill wins over a draining handshake in the same cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        imm_d       = imm_q;
        out_fmt_d   = out_fmt_q;
        if (s2_adv) begin
            out_valid_d = 1'b1;
            imm_d       = ext;
            out_fmt_d   = s1_fmt_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_instr_q  <= '0;
            s1_fmt_q    <= '0;
            out_valid_q <= 1'b0;
            imm_q       <= '0;
            out_fmt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_instr_q  <= s1_instr_d;
            s1_fmt_q    <= s1_fmt_d;
            out_valid_q <= out_valid_d;
            imm_q       <= imm_d;
            out_fmt_q   <= out_fmt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign imm       = imm_q;
    assign out_fmt   = out_fmt_q;

endmodule
